tft_pixel_scanner: RTL and testbench

//  Consumes horizontal and vertical sync/DE strobes from the two TFT sync generators.

---
 rtl/tft_pixel_scanner.sv | 171 +++++++++++++++++
 tb/tb_tft_pixel_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_pixel_scanner.sv
// tft_pixel_scanner
//   Turns the TFT horizontal/vertical sync and data-enable strobes into
//   registered pixel coordinates for the pong renderer.
//
//   Optional feature macro: TFT_FRAME_CNT_EN (adds the frame_cnt port).
//
// Ports
//   clk          in   pixel clock
//   nrst         in   asynchronous active-low reset
//   h_sync       in   horizontal sync, low during the sync pulse
//   h_de         in   horizontal data enable
//   v_sync       in   vertical sync, low during the sync pulse
//   v_de         in   vertical data enable
//   x            out  column of the current pixel (valid with pix_valid)
//   y            out  row of the current pixel (valid with pix_valid)
//   pix_valid    out  x/y address an active pixel
//   line_start   out  one-cycle pulse on the first pixel of each line
//   frame_start  out  one-cycle pulse on pixel (0,0) of each frame
//   overrun      out  sticky lock/size error, cleared by v_sync fall
//   frame_cnt    out  completed frames, wraps 255->0 (TFT_FRAME_CNT_EN only)
module tft_pixel_scanner #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           h_sync,
    input  logic           h_de,
    input  logic           v_sync,
    input  logic           v_de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           pix_valid,
    output logic           line_start,
    output logic           frame_start,
    output logic           overrun
`ifdef TFT_FRAME_CNT_EN
    ,
    output logic [7:0]     frame_cnt
`endif
);

    localparam logic [1:0] WAIT_FRAME = 2'd0;
    localparam logic [1:0] WAIT_LINE  = 2'd1;
    localparam logic [1:0] IN_LINE    = 2'd2;

    localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

    function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
        return (v >= X_MAX) ? X_MAX : v + 1'b1;
    endfunction

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
        return (v >= Y_MAX) ? Y_MAX : v + 1'b1;
    endfunction

    logic       h_sync_p0, h_de_p0, v_sync_p0, v_de_p0;
    logic       h_de_p1, v_sync_p1;
    logic [1:0] state;
    logic       first_line;
    logic       frame_edge, line_edge, de_p0;

    // Stage 0: input sampling, plus one-cycle history for edge detection.
    // History resets low so a sync held low through reset is not a fall.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            h_sync_p0 <= 1'b0;
            h_de_p0   <= 1'b0;
            v_sync_p0 <= 1'b0;
            v_de_p0   <= 1'b0;
            h_de_p1   <= 1'b0;
            v_sync_p1 <= 1'b0;
        end else begin
            h_sync_p0 <= h_sync;
            h_de_p0   <= h_de;
            v_sync_p0 <= v_sync;
            v_de_p0   <= v_de;
            h_de_p1   <= h_de_p0;
            v_sync_p1 <= v_sync_p0;
        end
    end

    assign frame_edge = v_sync_p1 & ~v_sync_p0;
    assign line_edge  = h_de_p0 & ~h_de_p1 & v_de_p0;
    assign de_p0      = h_de_p0 & v_de_p0;

    // Stage 1: scan FSM and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= WAIT_FRAME;
            first_line  <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (frame_edge) begin
                // Frame boundary beats a coincident line boundary.
                state      <= WAIT_LINE;
                first_line <= 1'b1;
                overrun    <= 1'b0;
                pix_valid  <= 1'b0;
            end else begin
                case (state)
                    WAIT_FRAME: begin
                        pix_valid <= 1'b0;
                    end
                    WAIT_LINE: begin
                        if (line_edge) begin
                            state      <= IN_LINE;
                            x          <= '0;
                            pix_valid  <= 1'b1;
                            line_start <= 1'b1;
                            if (first_line) begin
                                y           <= '0;
                                frame_start <= 1'b1;
                                first_line  <= 1'b0;
                            end else begin
                                y <= sat_inc_y(y);
                                if (y >= Y_MAX)
                                    overrun <= 1'b1;
                            end
                        end else begin
                            pix_valid <= 1'b0;
                        end
                    end
                    IN_LINE: begin
                        if (de_p0) begin
                            x         <= sat_inc_x(x);
                            pix_valid <= 1'b1;
                            // Too many pixels, or h_sync active mid-line: lost lock.
                            if (x >= X_MAX || !h_sync_p0)
                                overrun <= 1'b1;
                        end else begin
                            pix_valid <= 1'b0;
                            state     <= WAIT_LINE;
                        end
                    end
                    default: begin
                        pix_valid <= 1'b0;
                        state     <= WAIT_FRAME;
                    end
                endcase
            end
        end
    end

`ifdef TFT_FRAME_CNT_EN
    logic seen_frame;

    // The first v_sync fall after reset only opens the first frame.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            seen_frame <= 1'b0;
            frame_cnt  <= '0;
        end else if (frame_edge) begin
            seen_frame <= 1'b1;
            if (seen_frame)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tft_pixel_scanner.sv
module tb_tft_pixel_scanner;

    logic       clk = 1'b0;
    logic       nrst;
    logic       h_sync, h_de, v_sync, v_de;
    logic [9:0] x;
    logic [9:0] y;
    logic       pix_valid, line_start, frame_start, overrun;
`ifdef TFT_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    tft_pixel_scanner #(
        .H_ACTIVE(480),
        .V_ACTIVE(272),
        .X_W(10),
        .Y_W(10)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .h_sync(h_sync),
        .h_de(h_de),
        .v_sync(v_sync),
        .v_de(v_de),
        .x(x),
        .y(y),
        .pix_valid(pix_valid),
        .line_start(line_start),
        .frame_start(frame_start),
        .overrun(overrun)
`ifdef TFT_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int   pv_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    int   fs_bad = 0, ls_bad = 0, pulse_bad = 0;
    int   last_x = 0, last_y = 0;
    logic ls_prev = 1'b0, fs_prev = 1'b0;

    always @(negedge clk) begin
        ls_prev <= line_start;
        fs_prev <= frame_start;
        if (pix_valid === 1'b1) begin
            pv_cnt <= pv_cnt + 1;
            last_x <= int'(x);
            last_y <= int'(y);
        end
        if (line_start === 1'b1) begin
            ls_cnt <= ls_cnt + 1;
            if (pix_valid !== 1'b1 || x !== 10'd0)
                ls_bad <= ls_bad + 1;
        end
        if (frame_start === 1'b1) begin
            fs_cnt <= fs_cnt + 1;
            if (line_start !== 1'b1 || x !== 10'd0 || y !== 10'd0)
                fs_bad <= fs_bad + 1;
        end
        if ((line_start === 1'b1 && ls_prev === 1'b1) ||
            (frame_start === 1'b1 && fs_prev === 1'b1))
            pulse_bad <= pulse_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vfall();
        v_sync = 1'b0;
        step(2);
        v_sync = 1'b1;
        step(2);
    endtask

    task automatic line(input int w, input int gap);
        h_de = 1'b1;
        step(w);
        h_de = 1'b0;
        step(gap);
    endtask

    int b_pv, b_ls, b_fs;

    initial begin
        nrst   = 1'b0;
        h_sync = 1'b1;
        v_sync = 1'b1;
        h_de   = 1'b0;
        v_de   = 1'b0;
        step(3);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_overrun", overrun, 0);
`ifdef TFT_FRAME_CNT_EN
        check("rst_frame_cnt", frame_cnt, 0);
`endif
        nrst = 1'b1;
        step(2);

        // DE activity before any frame boundary is ignored
        b_pv = pv_cnt;
        v_de = 1'b1;
        line(10, 3);
        line(5, 3);
        check("noframe_pv_cnt", pv_cnt - b_pv, 0);
        check("noframe_x", x, 0);
        check("noframe_y", y, 0);
        v_de = 1'b0;
        step(2);

        // Frame of 272 lines; first and last lines full width
        vfall();
        v_de = 1'b1;
        b_pv = pv_cnt;
        b_ls = ls_cnt;
        b_fs = fs_cnt;
        for (int l = 0; l < 272; l++)
            line((l == 0 || l == 271) ? 480 : 4, 3);
        check("frame_fs_cnt", fs_cnt - b_fs, 1);
        check("frame_ls_cnt", ls_cnt - b_ls, 272);
        check("frame_pv_cnt", pv_cnt - b_pv, 2040);
        check("frame_last_x", last_x, 479);
        check("frame_last_y", last_y, 271);
        check("frame_overrun", overrun, 0);
        check("frame_pv_idle", pix_valid, 0);

        // One line too many: y holds at 271, line_start still pulses
        line(4, 3);
        check("yover_ls_cnt", ls_cnt - b_ls, 273);
        check("yover_last_y", last_y, 271);
        check("yover_last_x", last_x, 3);
        check("yover_overrun", overrun, 1);
        v_de = 1'b0;
        step(2);

        // Long line: x saturates, overrun sticky until next v_sync fall
        vfall();
        check("vfall_clears_ov", overrun, 0);
        v_de = 1'b1;
        h_de = 1'b1;
        step(485);
        check("xsat_x", x, 479);
        check("xsat_y", y, 0);
        check("xsat_pv", pix_valid, 1);
        check("xsat_overrun", overrun, 1);
        h_de = 1'b0;
        step(3);
        check("xsat_pv_end", pix_valid, 0);
        check("xsat_ov_sticky", overrun, 1);
        vfall();
        check("xsat_ov_cleared", overrun, 0);

        // v_sync fall coincident with h_de rise: no pixel, next rise is (0,0)
        b_pv = pv_cnt;
        v_sync = 1'b0;
        h_de = 1'b1;
        step(2);
        check("coinc_pv", pix_valid, 0);
        v_sync = 1'b1;
        step(4);
        check("coinc_pv_cnt", pv_cnt - b_pv, 0);
        h_de = 1'b0;
        step(3);
        h_de = 1'b1;
        step(2);
        check("coinc_next_pv", pix_valid, 1);
        check("coinc_next_fs", frame_start, 1);
        check("coinc_next_ls", line_start, 1);
        check("coinc_next_x", x, 0);
        check("coinc_next_y", y, 0);
        step(1);
        check("coinc_fs_1clk", frame_start, 0);
        h_de = 1'b0;
        step(3);

        // Reset in mid-frame at x=200, y=100
        vfall();
        for (int l = 0; l < 100; l++)
            line(4, 3);
        h_de = 1'b1;
        step(202);
        check("mid_x", x, 200);
        check("mid_y", y, 100);
        check("mid_pv", pix_valid, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_x", x, 0);
        check("async_y", y, 0);
        check("async_pv", pix_valid, 0);
        check("async_ls", line_start, 0);
        check("async_fs", frame_start, 0);
        check("async_ov", overrun, 0);
        step(1);
        nrst = 1'b1;
        b_pv = pv_cnt;
        h_de = 1'b0;
        step(3);
        line(4, 3);
        line(4, 3);
        check("post_rst_pv_cnt", pv_cnt - b_pv, 0);
        vfall();
        b_pv = pv_cnt;
        h_de = 1'b1;
        step(2);
        check("post_rst_fs", frame_start, 1);
        check("post_rst_y", y, 0);
        step(2);
        h_de = 1'b0;
        step(3);
        check("post_rst_pv_cnt2", pv_cnt - b_pv, 4);

`ifdef TFT_FRAME_CNT_EN
        // One v_sync fall since reset so far
        check("fcnt_first", frame_cnt, 0);
        for (int f = 0; f < 255; f++)
            vfall();
        check("fcnt_255", frame_cnt, 255);
        vfall();
        check("fcnt_wrap0", frame_cnt, 0);
        vfall();
        check("fcnt_wrap1", frame_cnt, 1);
`endif

        step(2);
        check("ls_coincidence", ls_bad, 0);
        check("fs_coincidence", fs_bad, 0);
        check("pulse_width", pulse_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
